mesh_frame_sequencer: RTL and testbench
=======================================

# mesh_frame_sequencer

Controller that sequences the 26x18 two-bit pixel mesh (`twobit_26x18_mesh`) for one frame at a time. It accepts 18 row words from an upstream valid/ready pixel stream and writes them into the mesh with `row`/`inp`. It then raises `high`, waits the fixed compute latency and captures the 468-bit `out` result. The captured frame goes to the contour-following stage downstream over a valid/ready handshake.

## Interface
Parameters:
- `COLS`, 26: pixels per row.
- `ROWS`, 18: rows per frame.
- `PIX_W`, 2: bits per pixel.
- `SETTLE_CYC`, 4: cycles from `mesh_high` rising to a valid `mesh_out`.
- `ROW_W`, 5: width of the row index.

Ports (clock: `clk`; reset: asynchronous, active-high `rst`):
- `clk`  in  1  Single clock; everything is rising-edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `s_valid`  in  1  Upstream row word valid.
- `s_ready`  out  1  Sequencer accepts a row.
- `s_data`  in  COLS*PIX_W  Row pixels, pixel 0 in bits [1:0].
- `s_last`  in  1  Marks the final row of a frame.
- `mesh_inp`  out  COLS*PIX_W  Row data to the mesh, registered.
- `mesh_row`  out  ROW_W  Row index to the mesh, registered.
- `mesh_high`  out  1  Mesh compute enable, registered.
- `mesh_out`  in  COLS*ROWS  Mesh result.
- `m_valid`  out  1  Captured frame valid.
- `m_ready`  in  1  Downstream accepts the frame.
- `m_frame`  out  COLS*ROWS  Captured mesh result.
- `frame_err`  out  1  One-cycle pulse on a framing error.
- `frame_cnt`  out  16  Delivered-frame count; wraps at 65535→0.

## Operation
States:
- LOAD:
  - `s_ready=1`. On each `s_valid&&s_ready`, register `s_data`→`mesh_inp` and `row_cnt`→`mesh_row`, then increment `row_cnt`.
  - `mesh_high=0`. The mesh writes `inp` into row `row` on every edge, so holding the previous values is idempotent.
- STAB: one cycle, `s_ready=0`. Lets the final row land in the mesh.
- RUN:
  - `mesh_high=1`. Settle counter runs 0..SETTLE_CYC-1.
  - At terminal count: `m_frame<=mesh_out`, `mesh_high<=0`, go to HOLD.
- HOLD: `m_valid=1`. On `m_ready`, increment `frame_cnt`, clear `row_cnt` and go to LOAD.

Transitions and framing rules:
- LOAD→STAB on acceptance of row ROWS-1, whether or not `s_last` is set.
- `s_last` missing on row ROWS-1: pulse `frame_err` and proceed normally.
- `s_last` on row < ROWS-1 (early end): pulse `frame_err`, discard the partial frame, set `row_cnt=0` and stay in LOAD. The mesh keeps stale rows, which the next frame overwrites.
- `s_ready=0` in STAB, RUN and HOLD. No frame overlap, because the mesh is a single resource.
- `m_frame` is stable for the whole time `m_valid=1`.
- `row_cnt` counts 0..ROWS-1 only and never reaches ROWS.

## Timing
- Reset values:
  - state=LOAD, `s_ready=1`.
  - `mesh_inp=0`, `mesh_row=0`, `mesh_high=0`.
  - `m_valid=0`, `m_frame=0`, `frame_err=0`, `frame_cnt=0`, `row_cnt=0`.
- Reset mid-frame (any state): all registers return to reset values asynchronously. A frame that was partially loaded or computing is lost, and no `m_valid` is produced for it.
- Throughput in LOAD: one row per cycle.
- Latency, with edge T = acceptance of the last row:
  - T+1: STAB→RUN, `mesh_high` rises.
  - T+1+SETTLE_CYC: capture edge; `m_valid` rises and `mesh_high` falls.
  - Default: `m_valid` is seen high 5 cycles after the last accept.
- Exiting HOLD: `m_valid` falls on the edge after `m_valid&&m_ready`, and `s_ready` rises on that same edge. Minimum frame period is ROWS+SETTLE_CYC+2 = 24 cycles.
- `frame_err` is asserted for exactly the cycle after the offending handshake.

## Structure
- Shared package `mesh_pkg` holds:
  - constants COLS, ROWS, PIX_W, SETTLE_CYC;
  - derived widths ROW_W, ROW_BITS=COLS*PIX_W, MESH_BITS=COLS*ROWS;
  - typedef `seq_state_t` {LOAD, STAB, RUN, HOLD}.
- Single module, no sub-module. The settle counter is $clog2(SETTLE_CYC) bits, inline.

## Test plan
- Reset, then 18 rows back-to-back: row i = {26{pix[i%6]}} with pix = {01,00,10,10,01,11}, `s_last` on row 17.
  - `mesh_row` steps 0..17 one per cycle.
  - `mesh_high` rises 1 cycle after the last accept.
  - `m_valid` rises 5 cycles after the last accept, with `m_frame` equal to the mesh model output.
  - `frame_cnt` becomes 1 after the `m_ready` handshake.
- Hold `m_ready=0` for 20 cycles:
  - `m_frame` stays constant.
  - `s_ready=0` throughout.
  - When `m_ready` is finally asserted, `s_ready` rises on the next edge.
- `s_last` on row 7: `frame_err` pulses one cycle and `row_cnt` returns to 0. A following full 18-row frame completes with no error.
- Row 17 sent with `s_last=0`: `frame_err` pulses and the frame still completes with `m_valid`.
- Assert `rst` during RUN, at cycle 2 of settle: `mesh_high`, `m_valid` and `frame_cnt` drop to 0 immediately. The next frame runs with nominal latency.
- Preload `frame_cnt=65535` by forcing the register, then deliver one frame: `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared constants and state encoding for the 26x18 two-bit mesh frame sequencer.
package mesh_pkg;

    localparam int COLS       = 26;
    localparam int ROWS       = 18;
    localparam int PIX_W      = 2;
    localparam int SETTLE_CYC = 4;
    localparam int ROW_W      = 5;
    localparam int ROW_BITS   = COLS * PIX_W;
    localparam int MESH_BITS  = COLS * ROWS;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        STAB = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mesh_frame_sequencer.sv
// Loads one frame of rows into the pixel mesh, runs it for the settle time,
// captures the result and hands it downstream over valid/ready.
module mesh_frame_sequencer #(
    parameter int COLS       = mesh_pkg::COLS,
    parameter int ROWS       = mesh_pkg::ROWS,
    parameter int PIX_W      = mesh_pkg::PIX_W,
    parameter int SETTLE_CYC = mesh_pkg::SETTLE_CYC,
    parameter int ROW_W      = mesh_pkg::ROW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [COLS*PIX_W-1:0]    s_data,
    input  logic                     s_last,
    output logic [COLS*PIX_W-1:0]    mesh_inp,
    output logic [ROW_W-1:0]         mesh_row,
    output logic                     mesh_high,
    input  logic [COLS*ROWS-1:0]     mesh_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [COLS*ROWS-1:0]     m_frame,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);
    import mesh_pkg::*;

    localparam int ROW_BITS  = COLS * PIX_W;
    localparam int MESH_BITS = COLS * ROWS;
    localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [ROW_W-1:0]       r_row_cnt;
    logic [SET_W-1:0]       r_settle;
    logic [ROW_BITS-1:0]    r_mesh_inp;
    logic [ROW_W-1:0]       r_mesh_row;
    logic                   r_mesh_high;
    logic [MESH_BITS-1:0]   r_m_frame;
    logic                   r_frame_err;
    logic [15:0]            r_frame_cnt;

    logic w_accept;
    logic w_last_row;
    logic w_settle_done;
    logic w_err;
    logic w_deliver;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_err         = 1'b0;
        w_deliver     = 1'b0;
        w_last_row    = (r_row_cnt == ROW_W'(ROWS - 1));
        w_settle_done = (r_settle == SET_W'(SETTLE_CYC - 1));
        case (r_state)
            LOAD: begin
                if (s_valid) begin
                    w_accept = 1'b1;
                    if (w_last_row) begin
                        w_next_state = STAB;
                        w_err        = ~s_last;
                    end else begin
                        w_err        = s_last;
                    end
                end
            end
            STAB: w_next_state = RUN;
            RUN: begin
                if (w_settle_done) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_next_state = LOAD;
                    w_deliver    = 1'b1;
                end
            end
            default: w_next_state = LOAD;
        endcase
    end

    // An early s_last drops the partial frame; the next frame rewrites every mesh row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cnt   <= '0;
            r_settle    <= '0;
            r_mesh_inp  <= '0;
            r_mesh_row  <= '0;
            r_mesh_high <= 1'b0;
            r_m_frame   <= '0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_err <= w_err;
            r_mesh_high <= (w_next_state == RUN);
            r_settle    <= (r_state == RUN) ? r_settle + SET_W'(1) : '0;
            if (w_accept) begin
                r_mesh_inp <= s_data;
                r_mesh_row <= r_row_cnt;
                r_row_cnt  <= (w_last_row || s_last) ? '0 : r_row_cnt + ROW_W'(1);
            end
            if (r_state == RUN && w_settle_done) begin
                r_m_frame <= mesh_out;
            end
            if (w_deliver) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_row_cnt   <= '0;
            end
        end
    end

    assign s_ready   = (r_state == LOAD);
    assign m_valid   = (r_state == HOLD);
    assign mesh_inp  = r_mesh_inp;
    assign mesh_row  = r_mesh_row;
    assign mesh_high = r_mesh_high;
    assign m_frame   = r_m_frame;
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mesh_frame_sequencer.sv
// Bench for mesh_frame_sequencer with a behavioural mesh and a frame scoreboard.
module tb_mesh_frame_sequencer;
    import mesh_pkg::*;

    typedef struct {
        int f;
        bit last_ok;
        int hold;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [ROW_BITS-1:0]   s_data = '0;
    logic                  s_last = 1'b0;
    logic [ROW_BITS-1:0]   mesh_inp;
    logic [ROW_W-1:0]      mesh_row;
    logic                  mesh_high;
    logic [MESH_BITS-1:0]  mesh_out;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [MESH_BITS-1:0]  m_frame;
    logic                  frame_err;
    logic [15:0]           frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic [MESH_BITS-1:0] sb [$];
    logic [1:0] pix [6] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
    vec_t tbl [4];

    mesh_frame_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mesh_inp  (mesh_inp),
        .mesh_row  (mesh_row),
        .mesh_high (mesh_high),
        .mesh_out  (mesh_out),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_frame   (m_frame),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Mesh model: rows written every edge, output meaningful only once settled.
    logic [ROW_BITS-1:0] mem [ROWS];
    int hc = 0;
    always @(posedge clk) begin
        if (mesh_row < ROW_W'(ROWS)) mem[mesh_row] <= mesh_inp;
        hc <= mesh_high ? hc + 1 : 0;
    end
    always_comb begin
        mesh_out = '0;
        if (hc >= SETTLE_CYC - 1) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mesh_out[r*COLS+c] = |mem[r][c*PIX_W +: PIX_W];
        end
    end

    function automatic logic [ROW_BITS-1:0] row_word(input int f, input int i);
        return {COLS{pix[(i + f) % 6]}};
    endfunction

    function automatic logic [MESH_BITS-1:0] exp_frame(input int f);
        logic [MESH_BITS-1:0] e;
        e = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                e[r*COLS+c] = |pix[(r + f) % 6];
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: frame delivered got 1 expected 0");
            end else begin
                logic [MESH_BITS-1:0] e;
                e = sb.pop_front();
                if (m_frame !== e) begin
                    n_errors++;
                    $display("FAIL m_frame: got %h expected %h", m_frame, e);
                end
            end
        end
    end

    task automatic send_rows(input int f, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            chk("s_ready_load", s_ready, 1);
            if (i > 0) chk("frame_err_mid", frame_err, 0);
            s_valid = 1'b1;
            s_data  = row_word(f, i);
            s_last  = (i == last_idx);
            @(posedge clk); #1;
            chk("mesh_row", mesh_row, i);
            chk("mesh_inp", mesh_inp, row_word(f, i));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int f, input bit last_ok, input int hold);
        int cyc;
        logic [MESH_BITS-1:0] saved;
        sb.push_back(exp_frame(f));
        send_rows(f, ROWS, last_ok ? ROWS - 1 : -1);
        chk("frame_err_last", frame_err, !last_ok);
        chk("s_ready_stab", s_ready, 0);
        chk("high_stab", mesh_high, 0);
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("high_rise", mesh_high, 1);
                chk("frame_err_clear", frame_err, 0);
            end
        end
        chk("m_valid_latency", cyc, SETTLE_CYC + 1);
        chk("high_fall", mesh_high, 0);
        saved = m_frame;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_frame_stable", (m_frame == saved), 1);
            chk("hold_s_ready", s_ready, 0);
            chk("hold_m_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        chk("exit_s_ready", s_ready, 1);
        chk("exit_m_valid", m_valid, 0);
        chk("frame_cnt", frame_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached got 1 expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{f: 0, last_ok: 1'b1, hold: 0};
        tbl[1] = '{f: 1, last_ok: 1'b1, hold: 20};
        tbl[2] = '{f: 2, last_ok: 1'b0, hold: 0};
        tbl[3] = '{f: 3, last_ok: 1'b1, hold: 5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_mesh_high", mesh_high, 0);
        chk("rst_mesh_row", mesh_row, 0);
        chk("rst_mesh_inp", mesh_inp, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_frame_zero", (m_frame == '0), 1);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            run_frame(tbl[k].f, tbl[k].last_ok, tbl[k].hold);
        end

        // Early end on row 7: partial frame discarded, next frame clean.
        send_rows(6, 8, 7);
        chk("early_err", frame_err, 1);
        chk("early_row_cnt", dut.r_row_cnt, 0);
        chk("early_s_ready", s_ready, 1);
        @(posedge clk); #1;
        chk("early_err_pulse", frame_err, 0);
        run_frame(7, 1'b1, 0);

        // Reset two cycles into settle.
        sb.push_back(exp_frame(4));
        send_rows(4, ROWS, ROWS - 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_high", mesh_high, 1);
        chk("pre_rst_cnt", frame_cnt, exp_cnt);
        rst = 1'b1;
        #1;
        chk("mid_rst_high", mesh_high, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk) rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", m_valid, 0);
        end
        run_frame(5, 1'b1, 0);

        // Counter wrap.
        force dut.r_frame_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frame_cnt;
        @(posedge clk); #1;
        chk("preload_cnt", frame_cnt, 65535);
        exp_cnt = 65535;
        run_frame(8, 1'b1, 0);
        chk("wrap_cnt_zero", frame_cnt, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
